// File: rtl/stream_arbiter_qos_aging.sv
// Packet-level N-to-1 stream arbiter with QoS priority, round-robin tie-break
// and starvation aging. A grant is taken in IDLE and held for the whole packet,
// until the last beat is accepted downstream.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   s_data_i     per-stream beat data
//   s_qos_i      per-stream QoS, sampled only on the arbitration cycle
//   s_last_i     per-stream last-beat flag
//   s_valid_i    per-stream valid
//   s_ready_o    per-stream ready (only the granted stream can be ready)
//   m_data_o     output beat data
//   m_qos_o      QoS captured when the current packet was granted
//   m_id_o       index of the granted stream
//   m_last_o     output last-beat flag
//   m_valid_o    output valid
//   m_ready_i    output ready
module stream_arbiter_qos_aging #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_QOS__WIDTH = 4,
  parameter int unsigned STREAM_COUNT = 2,
  parameter int unsigned AGE_WIDTH    = 4,
  parameter int unsigned AGE_LIMIT    = 15
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]   s_qos_i,
  input  logic [STREAM_COUNT-1:0]                     s_last_i,
  input  logic [STREAM_COUNT-1:0]                     s_valid_i,
  output logic [STREAM_COUNT-1:0]                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                     m_data_o,
  output logic [T_QOS__WIDTH-1:0]                     m_qos_o,
  output logic [$clog2(STREAM_COUNT)-1:0]             m_id_o,
  output logic                                        m_last_o,
  output logic                                        m_valid_o,
  input  logic                                        m_ready_i
);

  localparam int unsigned IdWidth = $clog2(STREAM_COUNT);
  localparam logic [IdWidth-1:0]   LastIdx  = IdWidth'(STREAM_COUNT - 1);
  localparam logic [AGE_WIDTH-1:0] AgeLimit = AGE_LIMIT[AGE_WIDTH-1:0];
  localparam logic [AGE_WIDTH-1:0] AgeMax   = '1;
  localparam logic                 AgeOn    = (AGE_LIMIT != 0);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                                state_q, state_d;
  logic [IdWidth-1:0]                    grant_q, grant_d;
  logic [IdWidth-1:0]                    last_grant_q, last_grant_d;
  logic [T_QOS__WIDTH-1:0]               qos_q, qos_d;
  logic [STREAM_COUNT-1:0][AGE_WIDTH-1:0] age_q, age_d;

  logic [STREAM_COUNT-1:0] aged;
  logic                    arb_cycle;
  logic                    win_found;
  logic [IdWidth-1:0]      win_idx;
  logic                    win_aged;
  logic [T_QOS__WIDTH-1:0] win_qos;
  logic                    last_hs;

  always_comb begin
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      aged[i] = AgeOn && (age_q[i] >= AgeLimit);
    end
  end

  // Visit streams in round-robin order starting after last_grant. A later
  // candidate only replaces the current one when its key {aged, qos} is
  // strictly larger, so equal keys resolve to the earliest in RR order.
  always_comb begin
    int unsigned        sum;
    logic [IdWidth-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_aged  = 1'b0;
    win_qos   = '0;
    sum       = 0;
    idx       = '0;
    for (int unsigned k = 1; k <= STREAM_COUNT; k++) begin
      sum = 32'(last_grant_q) + k;
      if (sum >= STREAM_COUNT) begin
        sum = sum - STREAM_COUNT;
      end
      idx = sum[IdWidth-1:0];
      if (s_valid_i[idx]) begin
        if (!win_found ||
            (aged[idx] && !win_aged) ||
            ((aged[idx] == win_aged) && (s_qos_i[idx] > win_qos))) begin
          win_found = 1'b1;
          win_idx   = idx;
          win_aged  = aged[idx];
          win_qos   = s_qos_i[idx];
        end
      end
    end
  end

  assign arb_cycle = (state_q == StIdle) && win_found;

  // Ages move only on an arbitration cycle: winner and idle streams clear,
  // waiting losers count up and saturate.
  always_comb begin
    age_d = age_q;
    if (arb_cycle) begin
      for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
        if (IdWidth'(i) == win_idx) begin
          age_d[i] = '0;
        end else if (s_valid_i[i]) begin
          age_d[i] = (age_q[i] == AgeMax) ? age_q[i] : age_q[i] + AGE_WIDTH'(1);
        end else begin
          age_d[i] = '0;
        end
      end
    end
  end

  // Datapath: pure pass-through from the granted stream while BUSY.
  always_comb begin
    m_data_o  = '0;
    m_qos_o   = '0;
    m_id_o    = '0;
    m_last_o  = 1'b0;
    m_valid_o = 1'b0;
    s_ready_o = '0;
    if (state_q == StBusy) begin
      m_data_o           = s_data_i[grant_q];
      m_qos_o            = qos_q;
      m_id_o             = grant_q;
      m_last_o           = s_last_i[grant_q];
      m_valid_o          = s_valid_i[grant_q];
      s_ready_o[grant_q] = m_ready_i;
    end
  end

  assign last_hs = s_valid_i[grant_q] & m_ready_i & s_last_i[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    qos_d        = qos_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StBusy;
          grant_d = win_idx;
          qos_d   = win_qos;
        end
      end
      StBusy: begin
        if (last_hs) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastIdx;
      qos_q        <= '0;
      age_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      qos_q        <= qos_d;
      age_q        <= age_d;
    end
  end

endmodule

// File: tb/tb_stream_arbiter_qos_aging.sv
module tb_stream_arbiter_qos_aging;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int QW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [QW-1:0] qos;
    logic          last;
  } beat_t;

  typedef struct {
    int            rel;
    int            id;
    logic [QW-1:0] qos;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0][DW-1:0]   s_data_i = '0;
  logic [N-1:0][QW-1:0]   s_qos_i = '0;
  logic [N-1:0]           s_last_i = '0;
  logic [N-1:0]           s_valid_i = '0;
  logic [N-1:0]           s_ready_o;
  logic [DW-1:0]          m_data_o;
  logic [QW-1:0]          m_qos_o;
  logic [$clog2(N)-1:0]   m_id_o;
  logic                   m_last_o;
  logic                   m_valid_o;
  logic                   m_ready_i = 1'b1;

  beat_t s_q0[$];
  beat_t s_q1[$];
  exp_t  exp_q[$];

  int            cyc = 0;
  int            t0 = 0;
  int            checks = 0;
  int            errors = 0;
  logic [N-1:0]  acc = '0;
  logic [N-1:0]  exp_rdy;

  stream_arbiter_qos_aging #(
    .T_DATA_WIDTH(DW),
    .T_QOS__WIDTH(QW),
    .STREAM_COUNT(N),
    .AGE_WIDTH(4),
    .AGE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data_i(s_data_i),
    .s_qos_i(s_qos_i),
    .s_last_i(s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o(m_data_o),
    .m_qos_o(m_qos_o),
    .m_id_o(m_id_o),
    .m_last_o(m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Producers: retire a beat accepted on the previous cycle, present the next.
  always @(posedge clk) begin
    #1;
    if (acc[0] && s_q0.size() > 0) void'(s_q0.pop_front());
    if (acc[1] && s_q1.size() > 0) void'(s_q1.pop_front());
    if (s_q0.size() > 0) begin
      s_valid_i[0] = 1'b1; s_data_i[0] = s_q0[0].data;
      s_qos_i[0] = s_q0[0].qos; s_last_i[0] = s_q0[0].last;
    end else begin
      s_valid_i[0] = 1'b0; s_data_i[0] = '0; s_qos_i[0] = '0; s_last_i[0] = 1'b0;
    end
    if (s_q1.size() > 0) begin
      s_valid_i[1] = 1'b1; s_data_i[1] = s_q1[0].data;
      s_qos_i[1] = s_q1[0].qos; s_last_i[1] = s_q1[0].last;
    end else begin
      s_valid_i[1] = 1'b0; s_data_i[1] = '0; s_qos_i[1] = '0; s_last_i[1] = 1'b0;
    end
  end

  // Monitor: sampled mid-cycle; a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    exp_t e;
    acc = s_valid_i & s_ready_o;
    if (rst_n && m_valid_o) begin
      exp_rdy = '0;
      if (m_ready_i) exp_rdy[m_id_o] = 1'b1;
      check("s_ready", 64'(s_ready_o), 64'(exp_rdy));
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {32'(cyc - t0 - 1), 8'(m_id_o), 4'(m_qos_o), 8'(m_data_o),
              1'(m_last_o)}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else if (!m_ready_i) begin
        check("stall_hold", 64'(m_data_o), 64'(exp_q[0].data));
      end else begin
        e = exp_q.pop_front();
        check("beat {rel,id,qos,data,last}",
              {32'(cyc - t0 - 1), 8'(m_id_o), 4'(m_qos_o), 8'(m_data_o), 1'(m_last_o)},
              {32'(e.rel), 8'(e.id), 4'(e.qos), 8'(e.data), 1'(e.last)});
      end
    end
  end

  task automatic add_beat(input int s, input logic [DW-1:0] d, input logic [QW-1:0] q,
                          input logic l);
    beat_t b;
    b.data = d; b.qos = q; b.last = l;
    if (s == 0) s_q0.push_back(b);
    else s_q1.push_back(b);
  endtask

  task automatic add_exp(input int rel, input int id, input logic [QW-1:0] q,
                         input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.rel = rel; e.id = id; e.qos = q; e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    check(name, {32'd0, 1'(m_valid_o), 1'(m_last_o), 2'(s_ready_o), 8'(m_data_o),
          4'(m_qos_o), 1'(m_id_o)}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_q0.delete(); s_q1.delete(); exp_q.delete();
    m_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start();
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_idle("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single stream, 3-beat packet.
    do_reset();
    start();
    add_beat(0, 8'hA0, 4'd3, 1'b0);
    add_beat(0, 8'hA1, 4'd3, 1'b0);
    add_beat(0, 8'hA2, 4'd3, 1'b1);
    add_exp(1, 0, 4'd3, 8'hA0, 1'b0);
    add_exp(2, 0, 4'd3, 8'hA1, 1'b0);
    add_exp(3, 0, 4'd3, 8'hA2, 1'b1);
    wait_done("t1_drain");
    @(negedge clk);
    check_idle("t1_idle_after");

    // Higher QoS packet goes first in full.
    do_reset();
    start();
    add_beat(0, 8'h20, 4'd2, 1'b0);
    add_beat(0, 8'h21, 4'd2, 1'b1);
    add_beat(1, 8'h50, 4'd5, 1'b0);
    add_beat(1, 8'h51, 4'd5, 1'b1);
    add_exp(1, 1, 4'd5, 8'h50, 1'b0);
    add_exp(2, 1, 4'd5, 8'h51, 1'b1);
    add_exp(4, 0, 4'd2, 8'h20, 1'b0);
    add_exp(5, 0, 4'd2, 8'h21, 1'b1);
    wait_done("t2_drain");

    // Equal QoS: round-robin alternation, one idle cycle between grants.
    do_reset();
    start();
    add_beat(0, 8'h30, 4'd4, 1'b1);
    add_beat(0, 8'h31, 4'd4, 1'b1);
    add_beat(1, 8'h40, 4'd4, 1'b1);
    add_beat(1, 8'h41, 4'd4, 1'b1);
    add_exp(1, 0, 4'd4, 8'h30, 1'b1);
    add_exp(3, 1, 4'd4, 8'h40, 1'b1);
    add_exp(5, 0, 4'd4, 8'h31, 1'b1);
    add_exp(7, 1, 4'd4, 8'h41, 1'b1);
    wait_done("t3_drain");

    // Aging (limit 3): low-QoS s0 wins its 4th arbitration.
    do_reset();
    start();
    add_beat(0, 8'h60, 4'd1, 1'b1);
    add_beat(1, 8'h90, 4'd9, 1'b1);
    add_beat(1, 8'h91, 4'd9, 1'b1);
    add_beat(1, 8'h92, 4'd9, 1'b1);
    add_beat(1, 8'h93, 4'd9, 1'b1);
    add_exp(1, 1, 4'd9, 8'h90, 1'b1);
    add_exp(3, 1, 4'd9, 8'h91, 1'b1);
    add_exp(5, 1, 4'd9, 8'h92, 1'b1);
    add_exp(7, 0, 4'd1, 8'h60, 1'b1);
    add_exp(9, 1, 4'd9, 8'h93, 1'b1);
    wait_done("t4_drain");

    // Backpressure on beat 2 for 3 cycles; mid-packet QoS change ignored.
    do_reset();
    start();
    add_beat(1, 8'h70, 4'd6, 1'b0);
    add_beat(1, 8'h71, 4'd6, 1'b0);
    add_beat(1, 8'h72, 4'd2, 1'b0);
    add_beat(1, 8'h73, 4'd2, 1'b1);
    add_exp(1, 1, 4'd6, 8'h70, 1'b0);
    add_exp(5, 1, 4'd6, 8'h71, 1'b0);
    add_exp(6, 1, 4'd6, 8'h72, 1'b0);
    add_exp(7, 1, 4'd6, 8'h73, 1'b1);
    repeat (3) @(posedge clk);
    #1 m_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_ready_i = 1'b1;
    wait_done("t5_drain");

    // Reset in the middle of an s1 packet, then an equal-QoS race.
    do_reset();
    start();
    add_beat(1, 8'h80, 4'd4, 1'b0);
    add_beat(1, 8'h81, 4'd4, 1'b0);
    add_beat(1, 8'h82, 4'd4, 1'b0);
    add_beat(1, 8'h83, 4'd4, 1'b1);
    add_exp(1, 1, 4'd4, 8'h80, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("t6_reset_outputs");
    check("t6_beats_before_reset", 64'(exp_q.size()), 64'd0);
    s_q0.delete(); s_q1.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start();
    add_beat(0, 8'h10, 4'd4, 1'b1);
    add_beat(1, 8'h11, 4'd4, 1'b1);
    add_exp(1, 0, 4'd4, 8'h10, 1'b1);
    add_exp(3, 1, 4'd4, 8'h11, 1'b1);
    wait_done("t6_drain");

    repeat (3) @(negedge clk);
    check_idle("final_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_arbiter_qos_aging.md
# stream_arbiter_qos_aging

Packet-level N-to-1 stream arbiter with QoS priority, round-robin tie-break and starvation aging. It is the next generation of the team's QoS stream arbiter and sits between STREAM_COUNT producer streams and one consumer stream, using the same port set as `stream_if`. A grant is held for a whole packet until the `last` beat is accepted. Streams that keep losing arbitration are aged until they override QoS.

## Interface
- T_DATA_WIDTH, 8: data width per beat.
- T_QOS__WIDTH, 4: QoS width. A larger value means higher priority.
- STREAM_COUNT, 2: number of input streams. Must be ≥2.
- AGE_WIDTH, 4: width of each per-stream age counter.
- AGE_LIMIT, 15: age at which a stream becomes "aged". A value of 0 disables aging. Must be ≤2^AGE_WIDTH−1.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data_i  in  [STREAM_COUNT][T_DATA_WIDTH]  input data.
- s_qos_i  in  [STREAM_COUNT][T_QOS__WIDTH]  input QoS, sampled at arbitration.
- s_last_i  in  STREAM_COUNT  last beat of a packet.
- s_valid_i  in  STREAM_COUNT  input valid.
- s_ready_o  out  STREAM_COUNT  input ready.
- m_data_o  out  T_DATA_WIDTH  output data.
- m_qos_o  out  T_QOS__WIDTH  QoS of the granted packet.
- m_id_o  out  $clog2(STREAM_COUNT)  index of the granted stream.
- m_last_o  out  1  output last.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  output ready.

## Operation
- FSM states:
  - IDLE: no grant is held.
  - BUSY: the grant is locked to stream `g`.
- IDLE with no s_valid_i bit set: stay in IDLE.
- IDLE with any s_valid_i bit set: arbitrate, register `g` and `qos_r = s_qos_i[g]`, then go to BUSY.
- Arbitration key per valid stream, in this order:
  1. The aged flag (age ≥ AGE_LIMIT and AGE_LIMIT≠0) beats any non-aged stream.
  2. Then higher s_qos_i wins.
  3. Ties go round-robin: search starts at last_grant+1 and wraps modulo STREAM_COUNT.
- Age update, applied only on an arbitration cycle:
  - The winner's age is cleared.
  - Each valid loser increments, saturating at 2^AGE_WIDTH−1.
  - Each non-valid stream is cleared.
  - Ages are held on all other cycles.
- BUSY datapath (combinational pass-through from stream g):
  - m_data_o=s_data_i[g], m_last_o=s_last_i[g], m_valid_o=s_valid_i[g].
  - s_ready_o[g]=m_ready_i. All other s_ready_o bits are 0.
  - m_id_o=g, m_qos_o=qos_r. A mid-packet s_qos_i change is ignored.
- BUSY, handshake (m_valid_o & m_ready_i) with m_last_o=1: last_grant←g, then go to IDLE.
- BUSY, s_valid_i[g] deasserted mid-packet: the grant is held and m_valid_o=0. No other stream is served.
- IDLE outputs: m_valid_o=0, m_last_o=0, s_ready_o=0, m_data_o=0, m_qos_o=0, m_id_o=0.

## Timing
- Reset, asynchronously: state=IDLE, last_grant=STREAM_COUNT−1 (so stream 0 wins the first tie), all ages=0, qos_r=0, g=0. All outputs take their IDLE values immediately.
- Arbitration latency: 1 cycle. The valid-in-IDLE cycle is the arbitration cycle. The first beat can transfer on the next cycle.
- Gap between packets: exactly 1 idle cycle after the last-beat handshake, because the next arbitration happens in IDLE.
- Single-beat packet: 1 arbitration cycle + 1 transfer cycle, so one packet at most every 2 cycles.
- Backpressure: with m_ready_i=0, the output holds, s_ready_o[g]=0 and no state changes. Input streams are required to hold data under AXI-Stream rules.
- Reset mid-packet: the packet is abandoned with no flush. After release, the first arbitration favours stream 0.
- Simultaneous arrival of a new valid and the last handshake: the new request is arbitrated in the following IDLE cycle.

## Test plan
- Stream 0 only, qos=3, 3-beat packet A0..A2, m_ready_i=1: arbitration on cycle 0, beats on cycles 1–3 with m_id_o=0, m_qos_o=3 and m_last_o on A2. IDLE on cycle 4.
- s0 qos=2 and s1 qos=5 both valid with 2-beat packets: s1's packet fully precedes s0's. s_ready_o[0]=0 throughout s1's packet.
- Both streams at qos=4, each sending single-beat packets continuously: m_id_o sequence is 0,1,0,1, with one idle cycle between grants.
- AGE_LIMIT=3, s0 qos=1 and s1 qos=9, both continuously valid with single-beat packets: s1 wins arbitrations 1–3 and s0 wins the 4th. s0's age then returns to 0.
- 4-beat packet on s1 with m_ready_i=0 on beat 2 for 3 cycles: m_data_o holds beat 2, s_ready_o=00, no beat is lost or duplicated. s1's qos changing mid-packet does not change m_qos_o.
- rst_n pulsed low during beat 2 of an s1 packet while s0 and s1 have equal qos: outputs go to 0 immediately. After release, stream 0 is granted first.
